// File: rtl/decoder_host_link.sv
// Host-side bridge for the decoder byte protocol: serialises start commands and measurement
// rounds onto the decoder input stream and parses iteration/cycle/correction results back.
module decoder_host_link #(
  parameter int unsigned GRID_WIDTH_X            = 4,
  parameter int unsigned GRID_WIDTH_Z            = 1,
  parameter int unsigned GRID_WIDTH_U            = 3,
  // Total correction bits per round as produced by the decoder for this grid.
  parameter int unsigned CORR_W                  = 14,
  parameter logic [7:0]  START_DECODING_MSG      = 8'h01,
  parameter logic [7:0]  MEASUREMENT_DATA_HEADER = 8'h02,
  localparam int unsigned MeasBytes = (GRID_WIDTH_X * GRID_WIDTH_Z + 7) / 8,
  localparam int unsigned MeasW     = 8 * MeasBytes,
  localparam int unsigned RW        = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [MeasW-1:0]  meas_data_i,
  input  logic              meas_valid_i,
  output logic              meas_ready_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [CORR_W-1:0] corr_data_o,
  output logic [RW-1:0]     corr_round_o,
  output logic              corr_valid_o,
  input  logic              corr_ready_i,
  output logic [7:0]        result_iterations_o,
  output logic [15:0]       result_cycles_o,
  output logic              result_valid_o,
  output logic              busy_o
);

  localparam int unsigned CorrBytes = (CORR_W + 7) / 8;
  localparam int unsigned BW        = (MeasBytes > 1) ? $clog2(MeasBytes) : 1;
  localparam int unsigned CbW       = (CorrBytes > 1) ? $clog2(CorrBytes) : 1;

  typedef enum logic [2:0] {TIdle, TStart, THeader, TPayload, TNext} tx_state_e;
  typedef enum logic [2:0] {RIter, RCycHi, RCycLo, RCorr, RPresent} rx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [MeasW-1:0] shift_q, shift_d;
  logic [BW-1:0]    byte_q, byte_d;
  logic [RW-1:0]    round_q, round_d;
  logic             resp_pending_q, resp_set, resp_clr;

  rx_state_e         rx_state_q, rx_state_d;
  logic [7:0]        iter_tmp_q, iter_tmp_d;
  logic [7:0]        cyc_hi_q, cyc_hi_d;
  logic [7:0]        res_iter_q, res_iter_d;
  logic [15:0]       res_cyc_q, res_cyc_d;
  logic [CORR_W-1:0] corr_q, corr_d;
  logic [CbW-1:0]    cbyte_q, cbyte_d;
  logic [RW-1:0]     rround_q, rround_d;

  always_comb begin
    tx_state_d    = tx_state_q;
    shift_d       = shift_q;
    byte_d        = byte_q;
    round_d       = round_q;
    resp_set      = 1'b0;
    start_ready_o = 1'b0;
    meas_ready_o  = 1'b0;
    tx_data_o     = 8'h00;
    tx_valid_o    = 1'b0;
    unique case (tx_state_q)
      TIdle: begin
        start_ready_o = 1'b1;
        meas_ready_o  = !start_valid_i && !resp_pending_q;
        if (start_valid_i) begin
          tx_state_d = TStart;
        end else if (meas_valid_i && meas_ready_o) begin
          shift_d    = meas_data_i;
          round_d    = '0;
          tx_state_d = THeader;
        end
      end
      TStart: begin
        tx_data_o  = START_DECODING_MSG;
        tx_valid_o = 1'b1;
        if (tx_ready_i) tx_state_d = TIdle;
      end
      THeader: begin
        tx_data_o  = MEASUREMENT_DATA_HEADER;
        tx_valid_o = 1'b1;
        if (tx_ready_i) begin
          byte_d     = '0;
          tx_state_d = TPayload;
        end
      end
      TPayload: begin
        tx_data_o  = shift_q[7:0];
        tx_valid_o = 1'b1;
        if (tx_ready_i) begin
          shift_d = shift_q >> 8;
          byte_d  = byte_q + 1'b1;
          if (byte_q == BW'(MeasBytes - 1)) begin
            if (round_q == RW'(GRID_WIDTH_U - 1)) begin
              resp_set   = 1'b1;
              tx_state_d = TIdle;
            end else begin
              tx_state_d = TNext;
            end
          end
        end
      end
      TNext: begin
        meas_ready_o = 1'b1;
        if (meas_valid_i) begin
          shift_d    = meas_data_i;
          round_d    = round_q + 1'b1;
          byte_d     = '0;
          tx_state_d = TPayload;
        end
      end
      default: tx_state_d = TIdle;
    endcase
  end

  always_comb begin
    rx_state_d     = rx_state_q;
    iter_tmp_d     = iter_tmp_q;
    cyc_hi_d       = cyc_hi_q;
    res_iter_d     = res_iter_q;
    res_cyc_d      = res_cyc_q;
    corr_d         = corr_q;
    cbyte_d        = cbyte_q;
    rround_d       = rround_q;
    resp_clr       = 1'b0;
    rx_ready_o     = 1'b1;
    corr_valid_o   = 1'b0;
    result_valid_o = 1'b0;
    unique case (rx_state_q)
      RIter: if (rx_valid_i) begin
        iter_tmp_d = rx_data_i;
        rx_state_d = RCycHi;
      end
      RCycHi: if (rx_valid_i) begin
        cyc_hi_d   = rx_data_i;
        rx_state_d = RCycLo;
      end
      RCycLo: if (rx_valid_i) begin
        res_iter_d = iter_tmp_q;
        res_cyc_d  = {cyc_hi_q, rx_data_i};
        cbyte_d    = '0;
        rx_state_d = RCorr;
      end
      RCorr: if (rx_valid_i) begin
        // Bits of the final byte beyond CORR_W have no destination and are dropped.
        for (int b = 0; b < int'(CORR_W); b++) begin
          if (cbyte_q == CbW'(b / 8)) corr_d[b] = rx_data_i[b % 8];
        end
        if (cbyte_q == CbW'(CorrBytes - 1)) begin
          cbyte_d    = '0;
          rx_state_d = RPresent;
        end else begin
          cbyte_d = cbyte_q + 1'b1;
        end
      end
      RPresent: begin
        rx_ready_o   = 1'b0;
        corr_valid_o = 1'b1;
        if (corr_ready_i) begin
          if (rround_q == RW'(GRID_WIDTH_U - 1)) begin
            result_valid_o = 1'b1;
            resp_clr       = 1'b1;
            rround_d       = '0;
            rx_state_d     = RIter;
          end else begin
            rround_d   = rround_q + 1'b1;
            rx_state_d = RCorr;
          end
        end
      end
      default: rx_state_d = RIter;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q     <= TIdle;
      shift_q        <= '0;
      byte_q         <= '0;
      round_q        <= '0;
      resp_pending_q <= 1'b0;
      rx_state_q     <= RIter;
      iter_tmp_q     <= '0;
      cyc_hi_q       <= '0;
      res_iter_q     <= '0;
      res_cyc_q      <= '0;
      corr_q         <= '0;
      cbyte_q        <= '0;
      rround_q       <= '0;
    end else begin
      tx_state_q     <= tx_state_d;
      shift_q        <= shift_d;
      byte_q         <= byte_d;
      round_q        <= round_d;
      // A new request completing in the same cycle as the old response wins.
      resp_pending_q <= resp_set ? 1'b1 : (resp_clr ? 1'b0 : resp_pending_q);
      rx_state_q     <= rx_state_d;
      iter_tmp_q     <= iter_tmp_d;
      cyc_hi_q       <= cyc_hi_d;
      res_iter_q     <= res_iter_d;
      res_cyc_q      <= res_cyc_d;
      corr_q         <= corr_d;
      cbyte_q        <= cbyte_d;
      rround_q       <= rround_d;
    end
  end

  assign corr_data_o         = corr_q;
  assign corr_round_o        = rround_q;
  assign result_iterations_o = res_iter_q;
  assign result_cycles_o     = res_cyc_q;
  assign busy_o              = (tx_state_q != TIdle) || resp_pending_q;

endmodule
